prbs_gen_par: RTL and testbench
===============================

// Module: prbs_gen_par
// PURPOSE
//  Parametrised successor to the single-bit PRBS31 source used by the HighSpeedLinks examples.
//  Advances a Fibonacci LFSR WIDTH serial steps per clock and emits WIDTH bits per clock,
//  for serializer/TX-model front ends. Features:
//   - run-time polynomial selection (PRBS7/9/15/23/31), seed load, output inversion
//   - counted single-bit error injection for BER/checker testing
// PARAMETERS
//  WIDTH     8     bits produced per clock (1..32)
//  MODE_RST  3'd4  polynomial selected out of reset (encoding as mode port)
// PORTS
//  clkV     in   1      clock, all state on rising edge
//  rstV_n   in   1      asynchronous active-low reset
//  en       in   1      advance generator this cycle
//  load     in   1      load seed and mode (priority over en)
//  mode     in   3      0=PRBS7 x7+x6+1, 1=PRBS9 x9+x5+1, 2=PRBS15 x15+x14+1, 3=PRBS23 x23+x18+1, 4=PRBS31 x31+x28+1
//  seed     in   31     seed; low P bits used (P = polynomial order)
//  inv      in   1      invert dout bits of the word being generated
//  err_inj  in   1      request one bit flip in the next generated word
//  dout     out  WIDTH  PRBS word; dout[0] earliest in time
//  dout_vld out  1      dout updated by the previous cycle's en
//  mode_q   out  3      active polynomial code
//  err_cnt  out  16     injected-error count, saturates at 16'hFFFF
// BEHAVIOUR
//  State: s[30:0], with only the low P bits meaningful; mode_q; err_pend; dout; dout_vld; err_cnt.
//  Reset (async, rstV_n=0):
//   - s = all ones in the low P bits, zeros above; mode_q = MODE_RST
//   - dout = 0, dout_vld = 0, err_pend = 0, err_cnt = 0
//  Serial step for order P with tap Q:
//   - fb = s[P-1] ^ s[Q-1]
//   - s = {s[P-2:0], fb}, masked to P bits
//   - output bit = fb
//  Priority each clock: load > en > idle.
//  load=1:
//   - mode_q = mode; codes 5..7 load as 4 (PRBS31)
//   - s = seed masked to P of the new mode; a masked value of 0 is replaced by all ones (no lock-up)
//   - dout holds; dout_vld = 0
//  en=1 (load=0):
//   - s advances WIDTH steps
//   - dout[i] = (bit of step i) ^ inv; dout_vld = 1
//   - latency 1 clock: the word is visible the cycle after en
//  en=0 and load=0: s and dout hold; dout_vld = 0.
//  Error injection:
//   - err_inj=1 sets err_pend; request is not lost while en=0 or load=1
//   - on the first en word with err_pend or err_inj set: dout[0] is flipped, err_pend is cleared,
//     err_cnt increments (saturating)
//   - only the output is corrupted; s is never corrupted
//   - err_inj in a cycle whose word consumes an already pending request merges into that
//     request: one flip, one count
//  mode and seed are ignored unless load=1; mode_q changes only on load.
//  Reset mid-stream: immediate return to reset values; the sequence restarts from all ones.
//  Period per mode: 2^P-1 serial bits. With WIDTH=1 and PRBS31, the state update is
//  shift-left with new bit in s[0].
// TESTING
//  T1 WIDTH=1, load mode=0 seed=7'h7F, en=1 -> dout bits 0,0,0,0,0,0,1,...; the sequence
//     repeats exactly after 127 words, with no earlier repeat of the 7-bit state.
//  T2 WIDTH=8, mode=2 seed=15'h7FFF, en for 4000 cycles -> every word equals 8 consecutive
//     steps of a serial reference model; dout_vld high one cycle after each en.
//  T3 load seed=0, mode=1 -> output identical to seed=9'h1FF; load mode=6 -> mode_q=4.
//  T4 err_inj pulsed with en=0, then en=1 for 3 cycles -> only the first word differs from
//     reference, in dout[0] only; err_cnt=1; later words match.
//  T5 inv=1 while running PRBS23 -> dout is the bitwise complement of the reference; the
//     sequence is unchanged after inv returns to 0.
//  T6 rstV_n asserted mid-stream with en=1 -> outputs zero immediately; after release the
//     stream restarts as after power-up, in mode MODE_RST.

Source files
------------

// File: rtl/prbs_gen_par.sv
// Parallel Fibonacci PRBS source (PRBS7/9/15/23/31), WIDTH serial steps per clock.
// Word appears one clock after en; en=0 simply stalls the generator with state held.
module prbs_gen_par #(
  parameter int         WIDTH    = 8,
  parameter logic [2:0] MODE_RST = 3'd4
) (
  input  logic             clkV,
  input  logic             rstV_n,
  input  logic             en,
  input  logic             load,
  input  logic [2:0]       mode,
  input  logic [30:0]      seed,
  input  logic             inv,
  input  logic             err_inj,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic [2:0]       mode_q,
  output logic [15:0]      err_cnt
);

  function automatic logic [2:0] normMode(input logic [2:0] m);
    return (m > 3'd4) ? 3'd4 : m;
  endfunction

  function automatic logic [30:0] modeMask(input logic [2:0] m);
    case (m)
      3'd0:    return 31'h0000_007F;
      3'd1:    return 31'h0000_01FF;
      3'd2:    return 31'h0000_7FFF;
      3'd3:    return 31'h007F_FFFF;
      default: return 31'h7FFF_FFFF;
    endcase
  endfunction

  function automatic logic fbBit(input logic [30:0] s, input logic [2:0] m);
    case (m)
      3'd0:    return s[6]  ^ s[5];
      3'd1:    return s[8]  ^ s[4];
      3'd2:    return s[14] ^ s[13];
      3'd3:    return s[22] ^ s[17];
      default: return s[30] ^ s[27];
    endcase
  endfunction

  logic [30:0]      sReg;
  logic [30:0]      sAdv;
  logic [WIDTH-1:0] wordBits;
  logic [2:0]       loadMode;
  logic [30:0]      loadSeed;
  logic             errPend;
  logic             errFire;

  // Unrolled serial walk: bit i of the word is the feedback of step i.
  always_comb begin
    sAdv     = sReg;
    wordBits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      wordBits[i] = fbBit(sAdv, mode_q);
      sAdv        = {sAdv[29:0], wordBits[i]} & modeMask(mode_q);
    end
  end

  // A zero seed would lock the LFSR, so it is replaced by all ones.
  always_comb begin
    loadMode = normMode(mode);
    loadSeed = seed & modeMask(loadMode);
    if (loadSeed == '0) loadSeed = modeMask(loadMode);
  end

  assign errFire = errPend | err_inj;

  always_ff @(posedge clkV or negedge rstV_n) begin
    if (!rstV_n) begin
      sReg     <= modeMask(normMode(MODE_RST));
      mode_q   <= MODE_RST;
      dout     <= '0;
      dout_vld <= 1'b0;
      errPend  <= 1'b0;
      err_cnt  <= '0;
    end else if (load) begin
      sReg     <= loadSeed;
      mode_q   <= loadMode;
      dout_vld <= 1'b0;
      errPend  <= errPend | err_inj;
    end else if (en) begin
      sReg     <= sAdv;
      dout     <= wordBits ^ {WIDTH{inv}} ^ WIDTH'(errFire);
      dout_vld <= 1'b1;
      errPend  <= 1'b0;
      if (errFire && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end else begin
      dout_vld <= 1'b0;
      errPend  <= errPend | err_inj;
    end
  end

endmodule

// File: tb/tb_prbs_gen_par.sv
// Directed bench: WIDTH=1 and WIDTH=8 instances share stimulus, checked against a serial model.
module tb_prbs_gen_par;

  logic        clkV = 1'b0;
  logic        rstV_n, en, load, inv, err_inj;
  logic [2:0]  mode;
  logic [30:0] seed;
  logic [0:0]  dout1;
  logic [7:0]  dout8;
  logic        vld1, vld8;
  logic [2:0]  mq1, mq8;
  logic [15:0] ec1, ec8;

  always #5 clkV = ~clkV;

  prbs_gen_par #(.WIDTH(1), .MODE_RST(3'd4)) u1 (
    .clkV(clkV), .rstV_n(rstV_n), .en(en), .load(load), .mode(mode), .seed(seed),
    .inv(inv), .err_inj(err_inj), .dout(dout1), .dout_vld(vld1), .mode_q(mq1), .err_cnt(ec1));

  prbs_gen_par #(.WIDTH(8), .MODE_RST(3'd4)) u8 (
    .clkV(clkV), .rstV_n(rstV_n), .en(en), .load(load), .mode(mode), .seed(seed),
    .inv(inv), .err_inj(err_inj), .dout(dout8), .dout_vld(vld8), .mode_q(mq8), .err_cnt(ec8));

  int nTotal = 0;
  int nBad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTotal++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Serial reference: order and tap per mode code.
  int ordT[5] = '{7, 9, 15, 23, 31};
  int tapT[5] = '{6, 5, 14, 18, 28};

  function automatic logic fbOf(input logic [30:0] s, input int m);
    return s[ordT[m]-1] ^ s[tapT[m]-1];
  endfunction

  function automatic logic [30:0] advS(input logic [30:0] s, input int m);
    logic [31:0] msk;
    logic [31:0] nx;
    msk = (32'd1 << ordT[m]) - 32'd1;
    nx  = {s, fbOf(s, m)} & msk;
    return nx[30:0];
  endfunction

  function automatic logic [30:0] seedMask(input logic [30:0] s, input int m);
    logic [31:0] msk;
    logic [31:0] v;
    msk = (32'd1 << ordT[m]) - 32'd1;
    v   = {1'b0, s} & msk;
    if (v == 32'd0) v = msk;
    return v[30:0];
  endfunction

  logic [30:0] rs1, rs8;
  int          rm;
  logic [7:0]  last8;
  logic        last1;
  logic        bits1 [0:299];
  logic [7:0]  w8a   [0:19];

  task automatic tick;
    @(posedge clkV);
    #1;
  endtask

  // One clock: update the model from the applied inputs, clock, then compare.
  task automatic cyc(input logic flip);
    logic       isAdv;
    logic [7:0] e8;
    logic       e1;
    e8 = '0;
    e1 = 1'b0;
    isAdv = en && !load;
    if (load) begin
      rm  = (mode > 3'd4) ? 4 : int'(mode);
      rs1 = seedMask(seed, rm);
      rs8 = rs1;
    end else if (en) begin
      e1  = fbOf(rs1, rm) ^ inv ^ flip;
      rs1 = advS(rs1, rm);
      for (int i = 0; i < 8; i++) begin
        e8[i] = fbOf(rs8, rm) ^ inv ^ ((i == 0) ? flip : 1'b0);
        rs8   = advS(rs8, rm);
      end
    end
    tick();
    chk("vld1", 32'(vld1), 32'(isAdv));
    chk("vld8", 32'(vld8), 32'(isAdv));
    if (isAdv) begin
      chk("dout1", 32'(dout1), 32'(e1));
      chk("dout8", 32'(dout8), 32'(e8));
      last8 = dout8;
      last1 = dout1[0];
    end
  endtask

  task automatic modelReset;
    rm  = 4;
    rs1 = 31'h7FFF_FFFF;
    rs8 = 31'h7FFF_FFFF;
  endtask

  initial begin
    int rep, dup;
    logic [6:0] wi, wj;
    logic [6:0] first7;
    rstV_n = 1'b0; en = 1'b0; load = 1'b0; inv = 1'b0; err_inj = 1'b0;
    mode = 3'd0; seed = '0;
    modelReset();
    #12;
    chk("rst_dout8", 32'(dout8), 32'h0);
    chk("rst_vld8",  32'(vld8),  32'h0);
    chk("rst_mode",  32'(mq8),   32'h4);
    chk("rst_cnt",   32'(ec8),   32'h0);
    chk("rst_dout1", 32'(dout1), 32'h0);
    tick();
    rstV_n = 1'b1;

    // T1: PRBS7, period and first bits on the serial instance
    load = 1'b1; mode = 3'd0; seed = 31'h7F;
    cyc(1'b0);
    chk("t1_mode", 32'(mq1), 32'h0);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0);
      bits1[i] = last1;
    end
    en = 1'b0;
    cyc(1'b0);
    for (int i = 0; i < 7; i++) first7[i] = bits1[i];
    chk("t1_first7", 32'(first7), 32'h40);
    rep = 0;
    for (int i = 0; i < 127; i++) if (bits1[i+127] !== bits1[i]) rep++;
    chk("t1_period", 32'(rep), 32'h0);
    dup = 0;
    for (int i = 0; i < 127; i++) begin
      for (int k = 0; k < 7; k++) wi[k] = bits1[i+k];
      for (int j = 0; j < i; j++) begin
        for (int k = 0; k < 7; k++) wj[k] = bits1[j+k];
        if (wi == wj) dup++;
      end
    end
    chk("t1_unique", 32'(dup), 32'h0);

    // T2: PRBS15, long run against the reference
    load = 1'b1; mode = 3'd2; seed = 31'h7FFF;
    cyc(1'b0);
    load = 1'b0; en = 1'b1;
    repeat (4000) cyc(1'b0);
    en = 1'b0;
    cyc(1'b0);

    // T3: zero seed behaves like all ones; illegal mode loads as PRBS31
    load = 1'b1; mode = 3'd1; seed = 31'h0;
    cyc(1'b0);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0);
      w8a[i] = last8;
    end
    en = 1'b0; load = 1'b1; seed = 31'h1FF;
    cyc(1'b0);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0);
      chk("t3_same", 32'(last8), 32'(w8a[i]));
    end
    en = 1'b0; load = 1'b1; mode = 3'd6; seed = 31'h5;
    cyc(1'b0);
    load = 1'b0;
    chk("t3_mode6_8", 32'(mq8), 32'h4);
    chk("t3_mode6_1", 32'(mq1), 32'h4);

    // T4: error injection, pending, merge and during load
    err_inj = 1'b1;
    cyc(1'b0);
    err_inj = 1'b0;
    cyc(1'b0);
    chk("t4_cnt0", 32'(ec8), 32'h0);
    en = 1'b1;
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    chk("t4_cnt1_8", 32'(ec8), 32'h1);
    chk("t4_cnt1_1", 32'(ec1), 32'h1);
    en = 1'b0; err_inj = 1'b1;
    cyc(1'b0);
    en = 1'b1;
    cyc(1'b1);
    err_inj = 1'b0;
    cyc(1'b0);
    chk("t4_merge", 32'(ec8), 32'h2);
    en = 1'b0; load = 1'b1; err_inj = 1'b1; mode = 3'd4; seed = 31'h123;
    cyc(1'b0);
    load = 1'b0; err_inj = 1'b0; en = 1'b1;
    cyc(1'b1);
    cyc(1'b0);
    chk("t4_load", 32'(ec8), 32'h3);
    err_inj = 1'b1;
    cyc(1'b1);
    err_inj = 1'b0;
    cyc(1'b0);
    chk("t4_direct", 32'(ec1), 32'h4);

    // T5: inversion on PRBS23
    en = 1'b0; load = 1'b1; mode = 3'd3; seed = 31'h7F_FFFF;
    cyc(1'b0);
    load = 1'b0; en = 1'b1;
    repeat (5) cyc(1'b0);
    inv = 1'b1;
    repeat (10) cyc(1'b0);
    inv = 1'b0;
    repeat (10) cyc(1'b0);

    // T6: asynchronous reset mid-stream
    repeat (3) cyc(1'b0);
    @(posedge clkV);
    #3;
    rstV_n = 1'b0;
    #1;
    chk("t6_dout8", 32'(dout8), 32'h0);
    chk("t6_vld8",  32'(vld8),  32'h0);
    chk("t6_mode",  32'(mq8),   32'h4);
    chk("t6_cnt",   32'(ec8),   32'h0);
    modelReset();
    tick();
    rstV_n = 1'b1;
    cyc(1'b0);
    chk("t6_first", 32'(last8), 32'h0);
    repeat (10) cyc(1'b0);
    en = 1'b0;
    cyc(1'b0);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
